key_state_ctrl: RTL and testbench
=================================

KEY_STATE_CTRL -- requirements
Module: key_state_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 8: number of tracked keys, 2..256.
REQ-002 SHALL have parameter KEY_W, default $clog2(NUM_KEYS): width of the key index.
REQ-003 SHALL have parameter TOGGLE_MASK, default all-zero (NUM_KEYS bits): bit i=1 makes key i a toggle key; bit i=0 makes it momentary.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2**20: auto-release interval in clk cycles, >=2.
REQ-005 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port ready, input, 1: event strobe from the UART decoder; may be held high for several cycles.
REQ-008 SHALL have port key_val, input, KEY_W: event key index.
REQ-009 SHALL have port press, input, 1: 1 = press event, 0 = release event.
REQ-010 SHALL have port clear, input, 1: synchronous release-all.
REQ-011 SHALL have port controls_out, output, NUM_KEYS: held/latched key state.
REQ-012 SHALL have port press_pulse, output, NUM_KEYS: one-cycle pulse on each 0->1 transition of controls_out.
REQ-013 SHALL have port release_pulse, output, NUM_KEYS: one-cycle pulse on each 1->0 transition of controls_out.
REQ-014 SHALL have port bad_key, output, 1: one-cycle pulse when an event carries key_val >= NUM_KEYS.
REQ-015 SHALL have port to_pulse, output, 1: one-cycle pulse when any key auto-releases.

Function
REQ-016 SHALL register ready into ready_q; an event SHALL be accepted only on a clock edge where ready=1 and ready_q=0, so one event is taken per strobe regardless of strobe length.
REQ-017 SHALL sample key_val and press on the accepting edge and update controls_out and the pulse outputs on that same edge (visible the following cycle, latency 1).
REQ-018 For a momentary key, press=1 SHALL set the bit and press=0 SHALL clear it; a repeated press or release that leaves the bit unchanged SHALL produce no pulse.
REQ-019 For a toggle key, press=1 SHALL invert the bit; press=0 SHALL be ignored.
REQ-020 An event with key_val >= NUM_KEYS SHALL leave the state unchanged and pulse bad_key.
REQ-021 clear=1 SHALL zero controls_out on the next edge, pulse release_pulse for every previously-set bit, and drop any event accepted on the same edge (clear has priority).
REQ-022 All pulse outputs SHALL be registered and SHALL be 0 on every cycle without a qualifying transition.

Reset
REQ-023 rst SHALL force controls_out, press_pulse, release_pulse, bad_key, to_pulse and all timers to 0 immediately, independent of clk.
REQ-024 rst SHALL set ready_q to 1, so a ready held high through reset release is not accepted; ready must first be seen low.
REQ-025 Reset asserted mid-event or mid-timeout SHALL discard the event or timer with no pulse.

Configuration
REQ-026 With macro KEY_TIMEOUT_EN defined, each momentary key SHALL have a counter that is loaded to 0 on every accepted press of that key and increments while the bit is 1.
REQ-027 On reaching TIMEOUT_CYCLES-1, that counter SHALL clear its bit, pulse release_pulse[i] and pulse to_pulse.
REQ-028 A press of key i accepted on the same edge that key i times out SHALL win: the bit stays 1, the counter reloads, and no pulses are produced.
REQ-029 Toggle keys SHALL never time out.
REQ-030 Without KEY_TIMEOUT_EN, no counters SHALL be built, to_pulse SHALL be tied to 0, and held keys SHALL persist until released or cleared.

Structure
REQ-031 Package key_ctrl_pkg SHALL hold the key-event struct typedef (key index, press), the default TIMEOUT_CYCLES constant and the counter-width helper function.
REQ-032 Sub-module key_timer (one per key, generated only under KEY_TIMEOUT_EN) SHALL hold the per-key counter and expose load, run and expire.

Verification (NUM_KEYS=8, TOGGLE_MASK=8'h01, TIMEOUT_CYCLES=16)
REQ-033 ready held high for 3 cycles with key 4, press=1 -> controls_out=8'h10 and press_pulse=8'h10 for exactly one cycle; no second event.
REQ-034 Events key 0 press, key 0 release, key 0 press -> controls_out bit0 goes 1, stays 1, then goes 0, with exactly one press_pulse and one release_pulse.
REQ-035 Event with key_val=3'b111 under NUM_KEYS=6 -> bad_key pulses once and controls_out is unchanged.
REQ-036 controls_out=8'h14 and clear asserted on the same edge as a key 1 press event -> controls_out=8'h00, release_pulse=8'h14, key 1 not set.
REQ-037 KEY_TIMEOUT_EN: press key 2 with no further events -> bit2 clears 15 cycles after set, with release_pulse[2] and to_pulse; a re-press of key 2 on the expiry edge keeps bit2=1.
REQ-038 rst asserted while ready is high and 8'h3C is held -> all outputs 0 immediately; after release, no event is taken until ready goes low and then high again.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared types, constants and helpers for the key state controller.
package key_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT = 2**20;

  typedef struct packed {
    logic [7:0] key;
    logic       press;
  } key_event_t;

  // Bits needed to count 0 .. cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_timer.sv
// Per-key auto-release counter; expire is asserted on the edge where the
// count would reach TIMEOUT_CYCLES-1 while the key is held.
module key_timer
  import key_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = run && (cnt == CW'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/key_state_ctrl.sv
// Tracks held/latched key state from UART key events, with edge pulses.
// Optional per-key auto-release is enabled by defining KEY_TIMEOUT_EN.
module key_state_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int                  NUM_KEYS       = 8,
  parameter int                  KEY_W          = $clog2(NUM_KEYS),
  parameter logic [NUM_KEYS-1:0] TOGGLE_MASK    = '0,
  parameter int                  TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic [KEY_W-1:0]    key_val,
  input  logic                press,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] controls_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic                bad_key,
  output logic                to_pulse
);

  if (TIMEOUT_CYCLES < 2 || NUM_KEYS < 2 || NUM_KEYS > 256) begin : g_param_check
    $error("key_state_ctrl: parameter out of range");
  end

  logic                ready_q;
  key_event_t          ev;
  logic                accept;
  logic                key_ok;
  logic                take;
  logic [NUM_KEYS-1:0] hit;
  logic [NUM_KEYS-1:0] expire;
  logic [NUM_KEYS-1:0] next;
  logic                timeout_any;

  assign ev     = '{key: 8'(key_val), press: press};
  assign accept = ready && !ready_q;
  assign key_ok = 32'(key_val) < NUM_KEYS;
  assign take   = accept && key_ok && !clear;

  always_comb begin
    hit         = '0;
    next        = controls_out;
    timeout_any = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = take && (ev.key == 8'(i));
      if (expire[i]) begin
        next[i] = 1'b0;
        // A press landing on the expiry edge wins and suppresses the timeout.
        if (!(hit[i] && ev.press)) timeout_any = 1'b1;
      end
      if (hit[i]) begin
        if (TOGGLE_MASK[i]) begin
          if (ev.press) next[i] = ~controls_out[i];
        end else begin
          next[i] = ev.press;
        end
      end
    end
    if (clear) begin
      next        = '0;
      timeout_any = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q       <= 1'b1;
      controls_out  <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      bad_key       <= 1'b0;
    end else begin
      ready_q       <= ready;
      controls_out  <= next;
      press_pulse   <= next & ~controls_out;
      release_pulse <= controls_out & ~next;
      bad_key       <= accept && !key_ok && !clear;
    end
  end

`ifdef KEY_TIMEOUT_EN
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    if (!TOGGLE_MASK[g]) begin : g_mom
      key_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (hit[g] && ev.press),
        .run   (controls_out[g]),
        .expire(expire[g])
      );
    end else begin : g_tog
      assign expire[g] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_pulse <= 1'b0;
    else     to_pulse <= timeout_any;
  end
`else
  assign expire   = '0;
  assign to_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_state_ctrl.sv
// Directed bench for key_state_ctrl (8-key and 6-key instances).
module tb_key_state_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [2:0] key_val;
  logic       press;
  logic       clear;

  logic [7:0] ctrl8, pp8, rp8;
  logic       bad8, to8;
  logic [5:0] ctrl6, pp6, rp6;
  logic       bad6, to6;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  key_state_ctrl #(
    .NUM_KEYS(8), .KEY_W(3), .TOGGLE_MASK(8'h01), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .key_val(key_val), .press(press),
    .clear(clear), .controls_out(ctrl8), .press_pulse(pp8),
    .release_pulse(rp8), .bad_key(bad8), .to_pulse(to8)
  );

  key_state_ctrl #(
    .NUM_KEYS(6), .KEY_W(3), .TOGGLE_MASK(6'h01), .TIMEOUT_CYCLES(16)
  ) dut6 (
    .clk(clk), .rst(rst), .ready(ready), .key_val(key_val), .press(press),
    .clear(clear), .controls_out(ctrl6), .press_pulse(pp6),
    .release_pulse(rp6), .bad_key(bad6), .to_pulse(to6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] k, input logic p, input logic c);
    ready   = r;
    key_val = k;
    press   = p;
    clear   = c;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rdy;
    logic [2:0] key;
    logic       prs;
    logic       clr;
    logic [7:0] ctrl;
    logic [7:0] pp;
    logic [7:0] rp;
    logic       bad;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [2:0] k, input logic p,
                              input logic c, input logic [7:0] ct, input logic [7:0] ppv,
                              input logic [7:0] rpv, input logic b);
    vec_t v;
    v.rdy = r; v.key = k; v.prs = p; v.clr = c;
    v.ctrl = ct; v.pp = ppv; v.rp = rpv; v.bad = b;
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    tbl[0]  = mk(1, 4, 1, 0, 8'h00, 8'h00, 8'h00, 0); // ready held from reset
    tbl[1]  = mk(0, 4, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    tbl[2]  = mk(1, 4, 1, 0, 8'h10, 8'h10, 8'h00, 0);
    tbl[3]  = mk(1, 4, 1, 0, 8'h10, 8'h00, 8'h00, 0);
    tbl[4]  = mk(1, 4, 1, 0, 8'h10, 8'h00, 8'h00, 0);
    tbl[5]  = mk(0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0);
    tbl[6]  = mk(1, 0, 1, 0, 8'h11, 8'h01, 8'h00, 0);
    tbl[7]  = mk(0, 0, 0, 0, 8'h11, 8'h00, 8'h00, 0);
    tbl[8]  = mk(1, 0, 0, 0, 8'h11, 8'h00, 8'h00, 0);
    tbl[9]  = mk(0, 0, 0, 0, 8'h11, 8'h00, 8'h00, 0);
    tbl[10] = mk(1, 0, 1, 0, 8'h10, 8'h00, 8'h01, 0);
    tbl[11] = mk(0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0);
    tbl[12] = mk(1, 4, 1, 0, 8'h10, 8'h00, 8'h00, 0);
    tbl[13] = mk(0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0);
    tbl[14] = mk(1, 2, 1, 0, 8'h14, 8'h04, 8'h00, 0);
    tbl[15] = mk(0, 0, 0, 0, 8'h14, 8'h00, 8'h00, 0);
    tbl[16] = mk(1, 1, 1, 1, 8'h00, 8'h00, 8'h14, 0);
    tbl[17] = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    tbl[18] = mk(1, 7, 1, 0, 8'h80, 8'h80, 8'h00, 0);
    tbl[19] = mk(0, 0, 0, 0, 8'h80, 8'h00, 8'h00, 0);
    tbl[20] = mk(1, 7, 0, 0, 8'h00, 8'h00, 8'h80, 0);
    tbl[21] = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    tbl[22] = mk(1, 5, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    tbl[23] = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    tbl[24] = mk(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0);

    rst = 1'b1; ready = 1'b1; key_val = 3'd4; press = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ctrl", 32'(ctrl8), 32'h0);
    check("reset pp", 32'(pp8), 32'h0);
    check("reset rp", 32'(rp8), 32'h0);
    check("reset bad", 32'(bad8), 32'h0);
    check("reset to", 32'(to8), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rdy, tbl[i].key, tbl[i].prs, tbl[i].clr);
      check($sformatf("v%0d ctrl", i), 32'(ctrl8), 32'(tbl[i].ctrl));
      check($sformatf("v%0d pp", i), 32'(pp8), 32'(tbl[i].pp));
      check($sformatf("v%0d rp", i), 32'(rp8), 32'(tbl[i].rp));
      check($sformatf("v%0d bad", i), 32'(bad8), 32'(tbl[i].bad));
      check($sformatf("v%0d to", i), 32'(to8), 32'h0);
    end

    // Out-of-range key on the 6-key instance.
    step(1, 3, 1, 0);
    check("k3 ctrl8", 32'(ctrl8), 32'h08);
    check("k3 ctrl6", 32'(ctrl6), 32'h08);
    step(0, 0, 0, 0);
    step(1, 7, 1, 0);
    check("bad6 k7", 32'(bad6), 32'h1);
    check("bad6 ctrl", 32'(ctrl6), 32'h08);
    check("bad6 pp", 32'(pp6), 32'h0);
    check("bad8 k7", 32'(bad8), 32'h0);
    check("k7 ctrl8", 32'(ctrl8), 32'h88);
    step(0, 0, 0, 0);
    check("bad6 once", 32'(bad6), 32'h0);
    check("bad6 ctrl hold", 32'(ctrl6), 32'h08);
    step(1, 6, 0, 0);
    check("bad6 k6", 32'(bad6), 32'h1);
    check("k6 rel ctrl8", 32'(ctrl8), 32'h88);
    check("k6 rel rp8", 32'(rp8), 32'h0);
    step(0, 0, 0, 1);
    check("clr2 ctrl", 32'(ctrl8), 32'h0);
    check("clr2 rp", 32'(rp8), 32'h88);
    step(0, 0, 0, 0);

    // Toggle key never times out.
    step(1, 0, 1, 0);
    check("tog on", 32'(ctrl8), 32'h01);
    repeat (20) step(0, 0, 0, 0);
    check("tog hold", 32'(ctrl8), 32'h01);
    check("tog no to", 32'(to8), 32'h0);
    step(1, 0, 1, 0);
    check("tog off", 32'(ctrl8), 32'h00);
    check("tog off rp", 32'(rp8), 32'h01);
    step(0, 0, 0, 0);

`ifdef KEY_TIMEOUT_EN
    step(1, 2, 1, 0);
    check("to set ctrl", 32'(ctrl8), 32'h04);
    check("to set pp", 32'(pp8), 32'h04);
    for (int k = 1; k <= 14; k++) begin
      step(0, 0, 0, 0);
      check($sformatf("to hold%0d ctrl", k), 32'(ctrl8), 32'h04);
      check($sformatf("to hold%0d to", k), 32'(to8), 32'h0);
    end
    step(0, 0, 0, 0);
    check("to exp ctrl", 32'(ctrl8), 32'h00);
    check("to exp rp", 32'(rp8), 32'h04);
    check("to exp to", 32'(to8), 32'h1);
    step(0, 0, 0, 0);
    check("to after to", 32'(to8), 32'h0);
    check("to after rp", 32'(rp8), 32'h0);

    step(1, 2, 1, 0);
    check("rp set ctrl", 32'(ctrl8), 32'h04);
    repeat (14) step(0, 0, 0, 0);
    step(1, 2, 1, 0);
    check("repress ctrl", 32'(ctrl8), 32'h04);
    check("repress rp", 32'(rp8), 32'h0);
    check("repress pp", 32'(pp8), 32'h0);
    check("repress to", 32'(to8), 32'h0);
    step(0, 0, 0, 0);
    check("repress hold", 32'(ctrl8), 32'h04);
    step(0, 0, 0, 1);
    check("repress clr", 32'(ctrl8), 32'h00);
    step(0, 0, 0, 0);
`else
    step(1, 2, 1, 0);
    check("persist set", 32'(ctrl8), 32'h04);
    repeat (20) step(0, 0, 0, 0);
    check("persist ctrl", 32'(ctrl8), 32'h04);
    check("persist to", 32'(to8), 32'h0);
    check("persist rp", 32'(rp8), 32'h0);
    step(0, 0, 0, 1);
    check("persist clr", 32'(rp8), 32'h04);
    step(0, 0, 0, 0);
`endif

    // Asynchronous reset mid-strobe with 8'h3C held.
    step(1, 2, 1, 0);
    step(0, 0, 0, 0);
    step(1, 3, 1, 0);
    step(0, 0, 0, 0);
    step(1, 4, 1, 0);
    step(0, 0, 0, 0);
    step(1, 5, 1, 0);
    check("pre-rst ctrl", 32'(ctrl8), 32'h3C);
    check("pre-rst pp", 32'(pp8), 32'h20);
    key_val = 3'd1;
    #2 rst = 1'b1;
    #1;
    check("async rst ctrl", 32'(ctrl8), 32'h0);
    check("async rst pp", 32'(pp8), 32'h0);
    check("async rst rp", 32'(rp8), 32'h0);
    check("async rst bad", 32'(bad8), 32'h0);
    check("async rst to", 32'(to8), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 1, 1, 0);
    check("post-rst held ctrl", 32'(ctrl8), 32'h0);
    check("post-rst held pp", 32'(pp8), 32'h0);
    step(1, 1, 1, 0);
    check("post-rst held2", 32'(ctrl8), 32'h0);
    step(0, 1, 1, 0);
    check("post-rst low", 32'(ctrl8), 32'h0);
    step(1, 1, 1, 0);
    check("post-rst accept ctrl", 32'(ctrl8), 32'h02);
    check("post-rst accept pp", 32'(pp8), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
